// File: rtl/fault_injector.sv
// Seeded single-event-upset injector: XORs a one-hot mask into one register target and reports detection or timeout.
// Injection starts delay+1 cycles after start. The result appears one cycle after the detection edge, or after TIMEOUT observe cycles.
module fault_injector #(
   parameter int          NUM_TARGETS = 8,
   parameter int          DATA_WIDTH  = 32,
   parameter int          DELAY_WIDTH = 16,
   parameter int          TIMEOUT     = 256,
   parameter logic [31:0] LFSR_SEED   = 32'hACE11234
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic [DELAY_WIDTH-1:0]         delay_i,
   input  logic [7:0]                     hold_i,
   input  logic                           rand_target_i,
   input  logic [$clog2(NUM_TARGETS)-1:0] target_sel_i,
   input  logic                           rand_bit_i,
   input  logic [$clog2(DATA_WIDTH)-1:0]  bit_sel_i,
   input  logic                           ftm_error_i,
   output logic                           inject_o,
   output logic [$clog2(NUM_TARGETS)-1:0] target_o,
   output logic [DATA_WIDTH-1:0]          mask_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           detected_o,
   output logic [15:0]                    latency_o,
   output logic [15:0]                    detect_count_o,
   output logic [15:0]                    miss_count_o
);

   localparam int          TW       = $clog2(NUM_TARGETS);
   localparam int          BW       = $clog2(DATA_WIDTH);
   localparam logic [31:0] TAPS     = 32'h80200003;
   localparam logic [31:0] SEED     = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
   localparam logic [15:0] OBS_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WAIT, INJECT, OBSERVE, DONE} state_t;

   state_t                 state;
   logic [31:0]            lfsr;
   logic                   ftm_prev;
   logic                   err_edge;
   logic [DELAY_WIDTH-1:0] dly_cnt;
   logic [7:0]             hold_cnt;
   logic [TW-1:0]          tgt_q;
   logic [BW-1:0]          bit_q;
   logic [TW-1:0]          tgt_pick;
   logic [BW-1:0]          bit_pick;
   logic [15:0]            lat_cnt;
   logic [15:0]            obs_cnt;

   function automatic logic [DATA_WIDTH-1:0] onehot(input logic [BW-1:0] b);
      logic [DATA_WIDTH-1:0] m;
      m    = '0;
      m[b] = 1'b1;
      return m;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign err_edge = ftm_error_i & ~ftm_prev;
   assign tgt_pick = rand_target_i ? lfsr[TW-1:0] : target_sel_i;
   assign bit_pick = rand_bit_i ? lfsr[4+BW:5] : bit_sel_i;

   // Free-running so a campaign's random picks depend only on cycles since reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr     <= SEED;
         ftm_prev <= 1'b0;
      end else begin
         lfsr     <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
         ftm_prev <= ftm_error_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         dly_cnt        <= '0;
         hold_cnt       <= '0;
         tgt_q          <= '0;
         bit_q          <= '0;
         lat_cnt        <= '0;
         obs_cnt        <= '0;
         inject_o       <= 1'b0;
         target_o       <= '0;
         mask_o         <= '0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         detected_o     <= 1'b0;
         latency_o      <= '0;
         detect_count_o <= '0;
         miss_count_o   <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  tgt_q    <= tgt_pick;
                  bit_q    <= bit_pick;
                  dly_cnt  <= delay_i;
                  hold_cnt <= (hold_i == 8'd0) ? 8'd1 : hold_i;
                  busy_o   <= 1'b1;
                  if (delay_i != '0) begin
                     state <= WAIT;
                  end else begin
                     state    <= INJECT;
                     inject_o <= 1'b1;
                     mask_o   <= onehot(bit_pick);
                     target_o <= tgt_pick;
                     lat_cnt  <= '0;
                  end
               end
            end
            WAIT: begin
               if (dly_cnt == DELAY_WIDTH'(1)) begin
                  state    <= INJECT;
                  inject_o <= 1'b1;
                  mask_o   <= onehot(bit_q);
                  target_o <= tgt_q;
                  lat_cnt  <= '0;
               end else begin
                  dly_cnt <= dly_cnt - DELAY_WIDTH'(1);
               end
            end
            INJECT, OBSERVE: begin
               lat_cnt <= sat_inc(lat_cnt);
               // A detection edge wins over both the hold expiry and the timeout.
               if (err_edge || (state == OBSERVE && obs_cnt == OBS_LAST)) begin
                  state      <= DONE;
                  inject_o   <= 1'b0;
                  mask_o     <= '0;
                  done_o     <= 1'b1;
                  detected_o <= err_edge;
                  latency_o  <= lat_cnt;
                  if (err_edge) detect_count_o <= sat_inc(detect_count_o);
                  else          miss_count_o   <= sat_inc(miss_count_o);
               end else if (state == INJECT) begin
                  if (hold_cnt <= 8'd1) begin
                     state    <= OBSERVE;
                     inject_o <= 1'b0;
                     mask_o   <= '0;
                     obs_cnt  <= '0;
                  end else begin
                     hold_cnt <= hold_cnt - 8'd1;
                  end
               end else begin
                  obs_cnt <= obs_cnt + 16'd1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fault_injector.sv
// Scoreboard bench for fault_injector: each campaign pushes its expected outcome, the done monitor pops and compares.
module tb_fault_injector;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [15:0] delay_i = '0;
   logic [7:0]  hold_i = '0;
   logic        rand_target_i = 1'b0;
   logic [2:0]  target_sel_i = '0;
   logic        rand_bit_i = 1'b0;
   logic [4:0]  bit_sel_i = '0;
   logic        ftm_error_i = 1'b0;
   logic        inject_o;
   logic [2:0]  target_o;
   logic [31:0] mask_o;
   logic        busy_o;
   logic        done_o;
   logic        detected_o;
   logic [15:0] latency_o;
   logic [15:0] detect_count_o;
   logic [15:0] miss_count_o;

   always #5 clk = ~clk;

   fault_injector dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .delay_i        (delay_i),
      .hold_i         (hold_i),
      .rand_target_i  (rand_target_i),
      .target_sel_i   (target_sel_i),
      .rand_bit_i     (rand_bit_i),
      .bit_sel_i      (bit_sel_i),
      .ftm_error_i    (ftm_error_i),
      .inject_o       (inject_o),
      .target_o       (target_o),
      .mask_o         (mask_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .detected_o     (detected_o),
      .latency_o      (latency_o),
      .detect_count_o (detect_count_o),
      .miss_count_o   (miss_count_o)
   );

   typedef struct {
      int          inj;
      int          len;
      int          done;
      bit          det;
      int          lat;
      bit          chk_lat;
      int          tgt;
      logic [31:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   rst_cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   exp_det = 0;
   int   exp_miss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [31:0] lfsr_after(input int n);
      logic [31:0] l;
      l = 32'hACE11234;
      for (int i = 0; i < n; i++) l = {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'd0);
      return l;
   endfunction

   // Output monitor: records the inject window and scores each done pulse.
   int          inj_first = -1;
   int          inj_len = 0;
   logic [31:0] inj_mask = '0;
   int          inj_tgt = 0;
   logic        inj_prev = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (inject_o && !inj_prev) begin
         inj_first = cyc;
         inj_len   = 0;
         inj_mask  = mask_o;
         inj_tgt   = int'(target_o);
      end
      if (inject_o) inj_len++;
      inj_prev = inject_o;
      if (done_o && !rst_i) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("inj_start", inj_first, e.inj);
            chk("inj_len", inj_len, e.len);
            chk("inj_mask", inj_mask, e.mask);
            chk("inj_target", inj_tgt, e.tgt);
            chk("done_target", target_o, e.tgt);
            chk("done_cycle", cyc, e.done);
            chk("detected", detected_o, e.det);
            chk("done_mask_zero", mask_o, 0);
            if (e.chk_lat) chk("latency", latency_o, e.lat);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_i   = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      chk("rst_inject", inject_o, 0);
      chk("rst_mask", mask_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_detected", detected_o, 0);
      chk("rst_latency", latency_o, 0);
      chk("rst_target", target_o, 0);
      chk("rst_det_cnt", detect_count_o, 0);
      chk("rst_miss_cnt", miss_count_o, 0);
      rst_i = 1'b0;
      exp_q.delete();
      rst_cyc  = cyc;
      exp_det  = 0;
      exp_miss = 0;
   endtask

   // k: ftm_error_i rise offset from first inject cycle (-1 = none); poke: cycle offset of a stray start (0 = none).
   task automatic campaign(input int dly, input int hld, input bit rt, input int ts,
                           input bit rb, input int bs, input int k, input int poke);
      exp_t        e;
      int          s;
      int          h;
      int          b;
      int          n;
      logic [31:0] l;
      s = cyc;
      l = lfsr_after(s - rst_cyc);
      h = (hld == 0) ? 1 : hld;
      b = rb ? int'(l[9:5]) : bs;
      e.inj  = s + 1 + dly;
      e.tgt  = rt ? int'(l[2:0]) : ts;
      e.mask = 32'd1 << b;
      if (k >= 0 && k < h + 256) begin
         e.det = 1'b1; e.lat = k; e.chk_lat = 1'b1;
         e.done = e.inj + k + 1;
         e.len  = (k + 1 < h) ? k + 1 : h;
      end else begin
         e.det = 1'b0; e.lat = 0; e.chk_lat = 1'b0;
         e.done = e.inj + h + 256;
         e.len  = h;
      end
      exp_q.push_back(e);
      delay_i       = 16'(dly);
      hold_i        = 8'(hld);
      rand_target_i = rt;
      target_sel_i  = 3'(ts);
      rand_bit_i    = rb;
      bit_sel_i     = 5'(bs);
      start_i       = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      if (poke > 0) begin
         while (cyc < s + poke) @(negedge clk);
         start_i      = 1'b1;
         target_sel_i = ~target_sel_i;
         bit_sel_i    = ~bit_sel_i;
         @(negedge clk);
         start_i = 1'b0;
      end
      if (k >= 0) begin
         while (cyc < e.inj + k) @(negedge clk);
         ftm_error_i = 1'b1;
         @(negedge clk);
         ftm_error_i = 1'b0;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", exp_q.size(), 0);
      @(negedge clk);
      if (e.det) exp_det++;
      else       exp_miss++;
      chk("det_count", detect_count_o, exp_det);
      chk("miss_count", miss_count_o, exp_miss);
      chk("idle_busy", busy_o, 0);
   endtask

   initial begin
      int s;
      do_reset();
      // Random picks taken in the first cycle after reset, then repeated after a second reset.
      campaign(2, 1, 1'b1, 0, 1'b1, 0, 3, 0);
      do_reset();
      campaign(2, 1, 1'b1, 0, 1'b1, 0, 3, 0);
      // Fixed target 5 / bit 7: timeout, detection at +4, early edge inside a long window.
      campaign(3, 2, 1'b0, 5, 1'b0, 7, -1, 0);
      campaign(3, 2, 1'b0, 5, 1'b0, 7, 4, 0);
      campaign(3, 10, 1'b0, 5, 1'b0, 7, 1, 0);
      // Random target with fixed top bit, LFSR well past the seed; edge on the first inject cycle.
      repeat (7) @(negedge clk);
      campaign(5, 4, 1'b1, 0, 1'b0, 31, 0, 0);
      // Zero delay and zero hold: single inject cycle, then timeout.
      campaign(0, 0, 1'b0, 0, 1'b0, 0, -1, 0);
      // Stray start during the wait phase must not disturb the campaign.
      campaign(20, 3, 1'b0, 2, 1'b0, 12, 2, 5);
      // Reset while injecting.
      s = cyc;
      delay_i = 16'd0; hold_i = 8'd10; rand_target_i = 1'b0; rand_bit_i = 1'b0;
      target_sel_i = 3'd6; bit_sel_i = 5'd3;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      chk("mid_inject_on", inject_o, 1);
      chk("mid_mask_on", mask_o, 32'h8);
      chk("mid_cnt_nonzero", (detect_count_o != 0) && (miss_count_o != 0), 1);
      do_reset();
      // Error line stuck high from reset never produces an edge.
      ftm_error_i = 1'b1;
      do_reset();
      campaign(1, 1, 1'b0, 3, 1'b0, 0, -1, 0);
      ftm_error_i = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
